// File: rtl/imm_gen_pkg.sv
// Shared definitions for the registered immediate generator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: RISC-V opcode values, immediate type codes, skid FSM states.
package imm_gen_pkg;

  // Major opcodes (instr[6:0]) that carry an immediate
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Immediate type codes presented on ov_Type
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;
  localparam logic [2:0] IMM_Z    = 3'd6;

  // Occupancy of the main/skid register pair
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decode and branch/jump/AUIPC target adder.
// Latency: 0 cycles (pure logic, feeds the pipe registers).
// Backpressure: none; output simply follows the inputs.
// Ports: i_instr (32b instruction), i_pc (XLEN PC) -> o_imm, o_type, o_target, o_illegal.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_ADD = 1
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_type,
  output logic [XLEN-1:0] o_target,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm32;
  logic        w_use_tgt;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];

  // Every immediate is first assembled as a 32-bit value whose bit 31 is
  // the sign; zimm leaves bit 31 clear so the common widening below
  // yields zero extension for it automatically.
  always_comb begin
    w_imm32   = '0;
    o_type    = IMM_NONE;
    o_illegal = 1'b0;
    w_use_tgt = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      // Compressed/illegal encodings override every opcode decode
      o_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OP_JALR, OP_LOAD, OP_IMM: begin
          o_type  = IMM_I;
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        end
        OP_IMM32: begin
          if (XLEN == 64) begin
            o_type  = IMM_I;
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          end
        end
        OP_STORE: begin
          o_type  = IMM_S;
          w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        end
        OP_BRANCH: begin
          o_type    = IMM_B;
          w_use_tgt = 1'b1;
          w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
        end
        OP_LUI, OP_AUIPC: begin
          o_type    = IMM_U;
          w_use_tgt = (w_opcode == OP_AUIPC);
          w_imm32   = {i_instr[31:12], 12'h000};
        end
        OP_JAL: begin
          o_type    = IMM_J;
          w_use_tgt = 1'b1;
          w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
        end
        OP_SYSTEM: begin
          if (w_funct3[2]) begin
            o_type  = IMM_Z;
            w_imm32 = {27'd0, i_instr[19:15]};
          end else if (w_funct3 != 3'b000) begin
            // CSR register forms: expose the CSR address as an I immediate
            o_type  = IMM_I;
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
          end
        end
        default: ;
      endcase
    end
  end

  // Widen to XLEN; replication count is always >= 1 for XLEN 32/64
  assign o_imm = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  generate
    if (PC_ADD != 0) begin : g_target
      // Modulo-2^XLEN add: carry out is intentionally dropped
      assign o_target = w_use_tgt ? (i_pc + o_imm) : '0;
    end else begin : g_no_target
      assign o_target = '0;
    end
  endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with 2-entry skid buffer (fetch -> decode).
// Latency: 1 cycle, accept at edge N gives o_Valid from N+1; 1 instr/cycle sustained.
// Backpressure: o_Ready depends only on state (drops when both entries are full).
// Ports: i_clk, i_rst (async high); in: i_Valid/o_Ready, iv_Instr, iv_Pc;
//        out: o_Valid/i_Ready, ov_Imm, ov_Type, ov_Target, o_Illegal.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_ADD = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [31:0]     iv_Instr,
  input  logic [XLEN-1:0] iv_Pc,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] ov_Imm,
  output logic [2:0]      ov_Type,
  output logic [XLEN-1:0] ov_Target,
  output logic            o_Illegal
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_dec;
  logic w_ld_main_skid;
  logic w_ld_skid;

  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_type;
  logic [XLEN-1:0] w_dec_target;
  logic            w_dec_illegal;

  logic [XLEN-1:0] r_main_imm;
  logic [2:0]      r_main_type;
  logic [XLEN-1:0] r_main_target;
  logic            r_main_illegal;

  logic [XLEN-1:0] r_skid_imm;
  logic [2:0]      r_skid_type;
  logic [XLEN-1:0] r_skid_target;
  logic            r_skid_illegal;

  imm_decode_comb #(
    .XLEN   (XLEN),
    .PC_ADD (PC_ADD)
  ) u_decode (
    .i_instr   (iv_Instr),
    .i_pc      (iv_Pc),
    .o_imm     (w_dec_imm),
    .o_type    (w_dec_type),
    .o_target  (w_dec_target),
    .o_illegal (w_dec_illegal)
  );

  // Ready comes from state only; held low while reset is asserted
  assign o_Ready    = (r_state != ST_FULL) && !i_rst;
  assign o_Valid    = (r_state != ST_EMPTY);
  assign w_in_fire  = i_Valid && o_Ready;
  assign w_out_fire = o_Valid && i_Ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_dec  = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt   = ST_ONE;
          w_ld_main_dec = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          // Streaming: main drains and refills in the same edge
          w_ld_main_dec = 1'b1;
        end else if (w_in_fire) begin
          w_state_nxt = ST_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_state_nxt    = ST_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_main_imm     <= '0;
      r_main_type    <= IMM_NONE;
      r_main_target  <= '0;
      r_main_illegal <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_type    <= IMM_NONE;
      r_skid_target  <= '0;
      r_skid_illegal <= 1'b0;
    end else begin
      if (w_ld_main_dec) begin
        r_main_imm     <= w_dec_imm;
        r_main_type    <= w_dec_type;
        r_main_target  <= w_dec_target;
        r_main_illegal <= w_dec_illegal;
      end else if (w_ld_main_skid) begin
        r_main_imm     <= r_skid_imm;
        r_main_type    <= r_skid_type;
        r_main_target  <= r_skid_target;
        r_main_illegal <= r_skid_illegal;
      end
      if (w_ld_skid) begin
        r_skid_imm     <= w_dec_imm;
        r_skid_type    <= w_dec_type;
        r_skid_target  <= w_dec_target;
        r_skid_illegal <= w_dec_illegal;
      end
    end
  end

  assign ov_Imm    = r_main_imm;
  assign ov_Type   = r_main_type;
  assign ov_Target = r_main_target;
  assign o_Illegal = r_main_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input stream.
// Directed vector table, reset/backpressure/throughput sequences, then random
// valid/ready traffic scored against an integer-arithmetic reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic        rin;
  logic [31:0] instr;
  logic [63:0] pc;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32, tgt32;
  logic [2:0]  typ32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64, tgt64;
  logic [2:0]  typ64;

  int total = 0;
  int bad   = 0;
  int nin   = 0;
  int nout  = 0;
  bit last_in;
  bit last_out;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .PC_ADD(1)) u32 (
    .i_clk(clk), .i_rst(rst), .i_Valid(vin), .o_Ready(rdy32),
    .iv_Instr(instr), .iv_Pc(pc[31:0]), .o_Valid(v32), .i_Ready(rin),
    .ov_Imm(imm32), .ov_Type(typ32), .ov_Target(tgt32), .o_Illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .PC_ADD(1)) u64 (
    .i_clk(clk), .i_rst(rst), .i_Valid(vin), .o_Ready(rdy64),
    .iv_Instr(instr), .iv_Pc(pc), .o_Valid(v64), .i_Ready(rin),
    .ov_Imm(imm64), .ov_Type(typ64), .ov_Target(tgt64), .o_Illegal(ill64)
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic [63:0] tgt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } rec_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    logic [31:0] tgt32;
    logic [63:0] tgt64;
    logic        ill;
  } vec_t;

  rec_t        q[$];
  vec_t        vt[15];
  logic [6:0]  ops[12];

  // Reference: build the immediate as a signed integer from the ISA field
  // layout, then reduce modulo 2^xl.
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input int xl);
    exp_t               e;
    longint             v;
    logic [63:0]        mask;
    logic [2:0]         f3;
    bit                 tg;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    e = '0; v = 0; tg = 1'b0; f3 = ins[14:12];
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1;
      return e;
    end
    case (ins[6:0])
      7'h67, 7'h03, 7'h13: begin e.typ = 3'd1; s12 = ins[31:20]; v = s12; end
      7'h1B: if (xl == 64) begin e.typ = 3'd1; s12 = ins[31:20]; v = s12; end
      7'h23: begin e.typ = 3'd2; s12 = {ins[31:25], ins[11:7]}; v = s12; end
      7'h63: begin
        e.typ = 3'd3; tg = 1'b1;
        s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = s13;
      end
      7'h37, 7'h17: begin
        e.typ = 3'd4; tg = (ins[6:0] == 7'h17);
        s32 = {ins[31:12], 12'h000}; v = s32;
      end
      7'h6F: begin
        e.typ = 3'd5; tg = 1'b1;
        s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = s21;
      end
      7'h73: begin
        if (f3[2]) begin e.typ = 3'd6; v = longint'(ins[19:15]); end
        else if (f3 != 3'd0) begin e.typ = 3'd1; s12 = ins[31:20]; v = s12; end
      end
      default: ;
    endcase
    e.imm = 64'(v) & mask;
    if (tg) e.tgt = (p + 64'(v)) & mask;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: score outputs at the falling edge, update the model queue
  // with the handshakes that will occur at the next rising edge.
  task automatic cycle();
    exp_t e32, e64;
    bit   fin, fout;
    @(negedge clk);
    chk("m_vld32", 64'(v32), 64'(q.size() != 0));
    chk("m_vld64", 64'(v64), 64'(q.size() != 0));
    chk("m_rdy32", 64'(rdy32), 64'(q.size() < 2));
    chk("m_rdy64", 64'(rdy64), 64'(q.size() < 2));
    if (q.size() != 0) begin
      e32 = model(q[0].ins, q[0].pc, 32);
      e64 = model(q[0].ins, q[0].pc, 64);
      chk("m_imm32", 64'(imm32), e32.imm);
      chk("m_typ32", 64'(typ32), 64'(e32.typ));
      chk("m_tgt32", 64'(tgt32), e32.tgt);
      chk("m_ill32", 64'(ill32), 64'(e32.ill));
      chk("m_imm64", imm64, e64.imm);
      chk("m_typ64", 64'(typ64), 64'(e64.typ));
      chk("m_tgt64", tgt64, e64.tgt);
      chk("m_ill64", 64'(ill64), 64'(e64.ill));
    end
    fin  = vin && rdy32;
    fout = v32 && rin;
    if (fout && q.size() != 0) void'(q.pop_front());
    if (fin) q.push_back('{ins: instr, pc: pc});
    last_in  = fin;
    last_out = fout;
    nin  += int'(fin);
    nout += int'(fout);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] p);
    bit ok;
    ok = 1'b0;
    vin = 1'b1; instr = ins; pc = p;
    for (int n = 0; n < 10 && !ok; n++) begin
      cycle();
      ok = last_in;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    vin = 1'b0;
  endtask

  task automatic drain();
    rin = 1'b1; vin = 1'b0;
    for (int n = 0; n < 10 && q.size() != 0; n++) cycle();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nout0;
    rst = 1'b1; vin = 1'b0; rin = 1'b0; instr = '0; pc = '0;
    last_in = 1'b0; last_out = 1'b0;

    //        ins           pc      imm32         imm64                  t32 t64 tgt32         tgt64                  ill
    vt[0]  = '{32'hFFF00093, 64'h0,   32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1, 32'h0,        64'h0,                 0};
    vt[1]  = '{32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3, 3, 32'hFC,       64'hFC,                0};
    vt[2]  = '{32'h800002B7, 64'h0,   32'h80000000, 64'hFFFFFFFF80000000, 4, 4, 32'h0,        64'h0,                 0};
    vt[3]  = '{32'h305755F3, 64'h0,   32'hE,        64'hE,                6, 6, 32'h0,        64'h0,                 0};
    vt[4]  = '{32'hFFFFF06F, 64'h0,   32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 5, 5, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE,  0};
    vt[5]  = '{32'h00000001, 64'h1234, 32'h0,       64'h0,                0, 0, 32'h0,        64'h0,                 1};
    vt[6]  = '{32'h0FF0009B, 64'h40,  32'h0,        64'hFF,               0, 1, 32'h0,        64'h0,                 0};
    vt[7]  = '{32'hFE112E23, 64'h0,   32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 2, 2, 32'h0,        64'h0,                 0};
    vt[8]  = '{32'h00001297, 64'h1000, 32'h1000,    64'h1000,             4, 4, 32'h2000,     64'h2000,              0};
    vt[9]  = '{32'h30529073, 64'h0,   32'h305,      64'h305,              1, 1, 32'h0,        64'h0,                 0};
    vt[10] = '{32'h00000073, 64'h0,   32'h0,        64'h0,                0, 0, 32'h0,        64'h0,                 0};
    vt[11] = '{32'h00000033, 64'h0,   32'h0,        64'h0,                0, 0, 32'h0,        64'h0,                 0};
    vt[12] = '{32'hFFFFF017, 64'h10,  32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 4, 4, 32'hFFFFF010, 64'hFFFFFFFFFFFFF010,  0};
    vt[13] = '{32'hFE000EE0, 64'h100, 32'h0,        64'h0,                0, 0, 32'h0,        64'h0,                 1};
    // funct3 is 000 here (zimm field set but SYSTEM/000 decodes as NONE)
    vt[14] = '{32'h305705F3, 64'h0,   32'h0,        64'h0,                0, 0, 32'h0,        64'h0,                 0};

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1B, 7'h73, 7'h33, 7'h0F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld32", 64'(v32), 64'd0);
    chk("rst_vld64", 64'(v64), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_typ32", 64'(typ32), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_rdy32", 64'(rdy32), 64'd1);
    chk("rst_rdy64", 64'(rdy64), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors: one instruction at a time, 1-cycle latency
    rin = 1'b1;
    for (int i = 0; i < 15; i++) begin
      vin = 1'b1; instr = vt[i].ins; pc = vt[i].pc;
      cycle();
      vin = 1'b0;
      chk("vec_vld32", 64'(v32), 64'd1);
      chk("vec_imm32", 64'(imm32), 64'(vt[i].imm32));
      chk("vec_typ32", 64'(typ32), 64'(vt[i].t32));
      chk("vec_tgt32", 64'(tgt32), 64'(vt[i].tgt32));
      chk("vec_ill32", 64'(ill32), 64'(vt[i].ill));
      chk("vec_imm64", imm64, vt[i].imm64);
      chk("vec_typ64", 64'(typ64), 64'(vt[i].t64));
      chk("vec_tgt64", tgt64, vt[i].tgt64);
      chk("vec_ill64", 64'(ill64), 64'(vt[i].ill));
      cycle();
    end
    drain();

    // Backpressure: fill both entries, stall 3 cycles, release, check order
    nout0 = nout;
    rin = 1'b0;
    send(32'h00100093, 64'h0);
    send(32'h00200093, 64'h4);
    chk("bp_full_rdy32", 64'(rdy32), 64'd0);
    chk("bp_full_rdy64", 64'(rdy64), 64'd0);
    vin = 1'b1; instr = 32'h00300093; pc = 64'h8;
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("bp_hold_rdy", 64'(rdy32), 64'd0);
      chk("bp_hold_imm32", 64'(imm32), 64'd1);
      chk("bp_hold_imm64", imm64, 64'd1);
    end
    rin = 1'b1;
    send(32'h00300093, 64'h8);
    send(32'h00400093, 64'hC);
    drain();
    chk("bp_out_count", 64'(nout - nout0), 64'd4);

    // Reset while FULL discards both entries
    rin = 1'b0;
    send(32'hFFF00093, 64'h0);
    send(32'hFE000EE3, 64'h100);
    chk("rf_full_rdy", 64'(rdy32), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rf_vld32", 64'(v32), 64'd0);
    chk("rf_imm32", 64'(imm32), 64'd0);
    chk("rf_typ32", 64'(typ32), 64'd0);
    chk("rf_tgt64", tgt64, 64'd0);
    chk("rf_ill64", 64'(ill64), 64'd0);
    @(posedge clk);
    #1;
    chk("rf_vld64_next", 64'(v64), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rf_rdy32_rel", 64'(rdy32), 64'd1);
    chk("rf_rdy64_rel", 64'(rdy64), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    cycle();

    // Throughput with both valid and ready held high
    rin = 1'b1; vin = 1'b1;
    nin = 0; nout = 0;
    for (int n = 0; n < 40; n++) begin
      instr = 32'h00000013 | (32'(n) << 20); pc = 64'(n * 4);
      cycle();
    end
    chk("tput_in", 64'(nin), 64'd40);
    chk("tput_out", 64'(nout), 64'd39);
    drain();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      logic [31:0] ri;
      vin = ($urandom_range(0, 3) != 0);
      rin = ($urandom_range(0, 3) != 0);
      ri = $urandom;
      k = $urandom_range(0, 12);
      if (k < 12) ri[6:0] = ops[k];
      if ($urandom_range(0, 15) == 0) ri[1:0] = 2'($urandom_range(0, 2));
      instr = ri;
      pc = {32'($urandom), 32'($urandom)};
      cycle();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
